// File: rtl/cpu_mem_bridge.sv
// Bridges the native CPU memory request onto a sequenced AXI-lite-style master.
// One transaction in flight; each handshake state is guarded by a timeout that aborts to RESP.
module cpu_mem_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_error,
  output logic        mem_axi_awvalid,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_awready,
  output logic        mem_axi_wvalid,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_wready,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_arready,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_instr;
  logic        r_arvalid, r_rvalid, r_awvalid, r_wvalid, r_mem_ready, r_bus_error;

  logic w_accept, w_rcapture, w_timeout, w_at_limit, w_unused;

  assign w_unused   = mem_axi_bvalid;
  assign w_at_limit = (r_cnt == CNT_LAST);

  // The awaited ready is tested before the limit so a ready on the last cycle wins.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_rcapture = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: if (mem_valid) begin
        w_accept = 1'b1;
        w_next   = (mem_wstrb == 4'b0000) ? S_AR : S_AW;
      end
      S_AR:   if (mem_axi_arready) w_next = S_R;
              else if (w_at_limit) w_timeout = 1'b1;
      S_R:    if (mem_axi_rready) begin
                w_rcapture = 1'b1;
                w_next     = S_RESP;
              end else if (w_at_limit) w_timeout = 1'b1;
      S_AW:   if (mem_axi_awready) w_next = S_W;
              else if (w_at_limit) w_timeout = 1'b1;
      S_W:    if (mem_axi_wready) w_next = S_RESP;
              else if (w_at_limit) w_timeout = 1'b1;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_RESP;
  end

  // Bus outputs are registered from the next state so they appear with the state itself.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_instr     <= 1'b0;
      r_rdata     <= '0;
      r_arvalid   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_mem_ready <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_arvalid   <= (w_next == S_AR);
      r_rvalid    <= (w_next == S_R);
      r_awvalid   <= (w_next == S_AW);
      r_wvalid    <= (w_next == S_W);
      r_mem_ready <= (w_next == S_RESP);

      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state != S_IDLE && r_state != S_RESP)
        r_cnt <= r_cnt + 16'd1;

      if (w_accept) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
        r_instr <= mem_instr;
      end

      if (w_rcapture)
        r_rdata <= mem_axi_rdata;
      else if (w_timeout && r_wstrb == 4'b0000)
        r_rdata <= ERR_DATA;

      if (w_timeout) r_bus_error <= 1'b1;
    end
  end

  assign mem_ready       = r_mem_ready;
  assign mem_rdata       = r_rdata;
  assign bus_error       = r_bus_error;
  assign mem_axi_awvalid = r_awvalid;
  assign mem_axi_awaddr  = r_addr;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = r_wvalid;
  assign mem_axi_wdata   = r_wdata;
  assign mem_axi_wstrb   = r_wstrb;
  assign mem_axi_bready  = 1'b1;
  assign mem_axi_arvalid = r_arvalid;
  assign mem_axi_araddr  = r_addr;
  assign mem_axi_arprot  = {r_instr, 2'b00};
  assign mem_axi_rvalid  = r_rvalid;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: directed vector table, reset-mid-read sequence and random
// transactions against a per-transaction outcome model; all inputs driven on the falling edge.
module tb_cpu_mem_bridge;

  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        CLK = 1'b0, RSTb = 1'b0;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, bus_error;
  logic [31:0] mem_rdata;
  logic        mem_axi_awvalid, mem_axi_awready, mem_axi_wvalid, mem_axi_wready;
  logic        mem_axi_bvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_arready;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_rdata;
  logic [2:0]  mem_axi_awprot, mem_axi_arprot;
  logic [3:0]  mem_axi_wstrb;

  cpu_mem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_error(bus_error),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awaddr(mem_axi_awaddr),
    .mem_axi_awprot(mem_axi_awprot), .mem_axi_awready(mem_axi_awready),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wdata(mem_axi_wdata),
    .mem_axi_wstrb(mem_axi_wstrb), .mem_axi_wready(mem_axi_wready),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_araddr(mem_axi_araddr),
    .mem_axi_arprot(mem_axi_arprot), .mem_axi_arready(mem_axi_arready),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ins;
    logic [31:0] a, wd;
    logic [3:0]  ws;
    int          d1, d2;
    logic [31:0] rd, exp_rd;
    logic        exp_e;
  } vec_t;

  vec_t        tbl[10];
  int          total = 0, bad = 0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        cur_ins;
  logic [31:0] cur_a, cur_wd, cur_rd;
  logic [3:0]  cur_ws;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  // kind: 0 idle, 1 AR, 2 R, 3 AW, 4 W, 5 RESP
  task automatic check_bus(input int kind, input logic [31:0] exp_rd, input logic exp_e);
    logic [4:0] ev;
    case (kind)
      0: ev = 5'b00000;
      1: ev = 5'b10000;
      2: ev = 5'b01000;
      3: ev = 5'b00100;
      4: ev = 5'b00010;
      default: ev = 5'b00001;
    endcase
    chk("valids{ar,r,aw,w,ready}",
        32'({mem_axi_arvalid, mem_axi_rvalid, mem_axi_awvalid, mem_axi_wvalid, mem_ready}),
        32'(ev));
    chk("bus_error", 32'(bus_error), 32'(exp_e));
    chk("mem_rdata", mem_rdata, exp_rd);
    if (kind == 1 || kind == 2) begin
      chk("araddr", mem_axi_araddr, cur_a);
      chk("arprot", 32'(mem_axi_arprot), 32'({cur_ins, 2'b00}));
    end
    if (kind == 3 || kind == 4) begin
      chk("awaddr", mem_axi_awaddr, cur_a);
      chk("awprot", 32'(mem_axi_awprot), 32'(0));
      chk("wdata", mem_axi_wdata, cur_wd);
      chk("wstrb", 32'(mem_axi_wstrb), 32'(cur_ws));
    end
  endtask

  task automatic chk_reset();
    check_bus(0, 32'h0, 1'b0);
    chk("rst_araddr", mem_axi_araddr, 32'h0);
    chk("rst_wdata", mem_axi_wdata, 32'h0);
    chk("rst_wstrb", 32'(mem_axi_wstrb), 32'h0);
    chk("rst_arprot", 32'(mem_axi_arprot), 32'h0);
    chk("bready", 32'(mem_axi_bready), 32'h1);
  endtask

  // Noise on every input the bridge must ignore in the current cycle.
  task automatic junk();
    mem_valid       = 1'($urandom);
    mem_instr       = 1'($urandom);
    mem_addr        = $urandom;
    mem_wdata       = $urandom;
    mem_wstrb       = 4'($urandom);
    mem_axi_arready = 1'($urandom);
    mem_axi_rready  = 1'($urandom);
    mem_axi_awready = 1'($urandom);
    mem_axi_wready  = 1'($urandom);
    mem_axi_bvalid  = 1'($urandom);
    mem_axi_rdata   = $urandom;
  endtask

  task automatic start_req(input logic ins, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
    @(negedge CLK);
    check_bus(0, m_rdata, m_err);
    junk();
    cur_ins = ins; cur_a = a; cur_wd = wd; cur_ws = ws;
    mem_valid = 1'b1; mem_instr = ins; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
  endtask

  // Memory-controller side of one handshake: the awaited ready arrives d cycles in.
  task automatic phase(input int kind, input int d, output bit to);
    to = 1'b1;
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge CLK);
      check_bus(kind, m_rdata, m_err);
      junk();
      case (kind)
        1: mem_axi_arready = (i == d);
        2: begin
          mem_axi_rready = (i == d);
          if (i == d) mem_axi_rdata = cur_rd;
        end
        3: mem_axi_awready = (i == d);
        default: mem_axi_wready = (i == d);
      endcase
      if (i == d) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_txn(input logic ins, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input int d1, input int d2,
                         input logic [31:0] rd, input logic [31:0] exp_rd, input logic exp_e);
    bit to;
    bit is_rd;
    is_rd  = (ws == 4'b0000);
    cur_rd = rd;
    start_req(ins, a, wd, ws);
    phase(is_rd ? 1 : 3, d1, to);
    if (!to) phase(is_rd ? 2 : 4, d2, to);
    @(negedge CLK);
    check_bus(5, exp_rd, exp_e);
    junk();
    m_rdata = exp_rd;
    m_err   = exp_e;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          to1, to2, tmo, is_rd;
    logic [31:0] ex_rd, a, wd, rd;
    logic [3:0]  ws;
    int          d1, d2;

    tbl[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1, 2, 32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[1] = '{1'b0, 32'h1000_0004, 32'hCAFE_F00D, 4'hF, 0, 1, 32'h0,         32'h1234_5678, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 32'h0000_A5A5, 32'h0000_A5A5, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 0, 0, 32'h0000_0055, 32'h0000_0055, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_0028, 32'h0,         4'h0, 2, 7, 32'h600D_F00D, 32'h600D_F00D, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_0008, 32'h1122_3344, 4'h3, 7, 7, 32'h0,         32'h600D_F00D, 1'b0};
    tbl[6] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 20, 0, 32'h0,        32'hDEAD_BEEF, 1'b1};
    tbl[7] = '{1'b0, 32'h0000_0040, 32'h5555_AAAA, 4'h1, 0, 9, 32'h0,         32'hDEAD_BEEF, 1'b1};
    tbl[8] = '{1'b0, 32'h0000_0034, 32'h0,         4'h0, 1, 1, 32'h0000_0077, 32'h0000_0077, 1'b1};
    tbl[9] = '{1'b0, 32'h0000_0038, 32'h0,         4'h0, 0, 8, 32'h0000_0099, 32'hDEAD_BEEF, 1'b1};

    mem_valid = 0; mem_instr = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    mem_axi_arready = 0; mem_axi_rready = 0; mem_axi_awready = 0; mem_axi_wready = 0;
    mem_axi_bvalid = 0; mem_axi_rdata = '0;
    RSTb = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset();
    RSTb = 1'b1;

    foreach (tbl[i])
      run_txn(tbl[i].ins, tbl[i].a, tbl[i].wd, tbl[i].ws, tbl[i].d1, tbl[i].d2,
              tbl[i].rd, tbl[i].exp_rd, tbl[i].exp_e);

    // Reset arriving while the read is waiting for rready.
    cur_rd = 32'h0;
    start_req(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    phase(1, 0, to1);
    @(negedge CLK);
    check_bus(2, m_rdata, m_err);
    junk();
    mem_axi_rready = 1'b0;
    RSTb = 1'b0;
    @(negedge CLK);
    RSTb = 1'b1;
    mem_valid = 0; mem_axi_arready = 0; mem_axi_rready = 0;
    mem_axi_awready = 0; mem_axi_wready = 0;
    m_rdata = '0;
    m_err   = 1'b0;
    chk_reset();
    run_txn(1'b0, 32'h0000_0060, 32'h0, 4'h0, 1, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0);

    // Random traffic: outcome derived from which handshake delays exceed the timeout window.
    for (int n = 0; n < 50; n++) begin
      a     = $urandom;
      wd    = $urandom;
      rd    = $urandom;
      ws    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d1    = $urandom_range(0, 10);
      d2    = $urandom_range(0, 10);
      is_rd = (ws == 4'h0);
      to1   = (d1 >= int'(TO));
      to2   = !to1 && (d2 >= int'(TO));
      tmo   = to1 || to2;
      ex_rd = is_rd ? (tmo ? ERRD : rd) : m_rdata;
      run_txn(1'($urandom), a, wd, ws, d1, d2, rd, ex_rd, m_err | tmo);
    end

    @(negedge CLK);
    mem_valid = 0; mem_axi_arready = 0; mem_axi_rready = 0;
    mem_axi_awready = 0; mem_axi_wready = 0;
    check_bus(0, m_rdata, m_err);
    @(negedge CLK);
    check_bus(0, m_rdata, m_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bridge.md
CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles spent in any one AXI handshake state before abort (legal range 2..65535).
REQ-002 SHALL have parameter ERR_DATA, default 32'hdeadbeef, meaning the read data returned to the CPU on timeout.
REQ-003 SHALL have these ports, one per line: name, direction, width, meaning.
- CLK  in  1  clock
- RSTb  in  1  reset: synchronous, active-low
- mem_valid  in  1  CPU native request; held high until mem_ready
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read, nonzero = write
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- bus_error  out  1  sticky timeout flag
- mem_axi_awvalid/awaddr/awprot  out  1/32/3  write address channel
- mem_axi_awready  in  1  write address accept
- mem_axi_wvalid/wdata/wstrb  out  1/32/4  write data channel
- mem_axi_wready  in  1  write data accept
- mem_axi_bvalid  in  1  unused
- mem_axi_bready  out  1  tied 1
- mem_axi_arvalid/araddr/arprot  out  1/32/3  read address channel
- mem_axi_arready  in  1  read address accept
- mem_axi_rvalid  out  1  read data request, held until rready
- mem_axi_rready  in  1  read data accept (one-cycle pulse from the memory controller)
- mem_axi_rdata  in  32  read data, valid while rready=1

Function
REQ-004 SHALL register every output; no combinational input-to-output path.
REQ-005 SHALL implement the states IDLE, AR, R, AW, W, and RESP.
REQ-006 IDLE: on mem_valid=1, SHALL latch mem_addr, mem_wdata, mem_wstrb and mem_instr, then go to AR if wstrb==0, else AW; the bus outputs for the new state SHALL be visible in the next cycle.
REQ-007 AR: SHALL drive arvalid=1 and araddr=latched addr; when arready is sampled 1, SHALL go to R, with arvalid=0 from the next cycle.
REQ-008 R: SHALL drive rvalid=1; when rready is sampled 1, SHALL capture rdata into mem_rdata, go to RESP, and drive rvalid=0 from the next cycle.
REQ-009 AW: SHALL drive awvalid=1; when awready is sampled 1, SHALL go to W.
REQ-010 W: SHALL drive wvalid=1, wdata and wstrb from the latches; when wready is sampled 1, SHALL go to RESP, with wvalid=0 from the next cycle.
REQ-011 RESP: SHALL drive mem_ready=1 for exactly one cycle, then return to IDLE.
REQ-012 IDLE after RESP: SHALL not accept a new request in the cycle mem_ready is high; the earliest next acceptance is the following cycle. This gives the downstream memory controller one cycle of rvalid/wvalid low so it can return to its idle state.
REQ-013 araddr, awaddr, wdata and wstrb SHALL stay stable from the first valid cycle until the transaction reaches RESP; the downstream memory controller samples the address one cycle after it asserts ready.
REQ-014 arprot SHALL be {mem_instr, 2'b00}; awprot SHALL be 3'b000.
REQ-015 mem_rdata SHALL hold its last value outside RESP; write transactions SHALL not modify it.
REQ-016 A 16-bit timeout counter SHALL clear on every state entry and increment each cycle spent in AR, R, AW, or W.
REQ-017 If the timeout counter reaches TIMEOUT-1 without the awaited ready, the bridge SHALL, in the next cycle:
- drop all valids;
- set bus_error=1;
- load ERR_DATA into mem_rdata (reads only);
- go to RESP.
REQ-018 A ready that arrives in the same cycle as the timeout threshold SHALL win: the transaction completes normally and bus_error is not set.
REQ-019 Changes on mem_valid, mem_addr, mem_wdata, or mem_wstrb outside IDLE SHALL be ignored.
REQ-020 An unsolicited ready (arready, rready, awready, or wready in a state not awaiting it) SHALL be ignored.

Reset
REQ-021 On RSTb=0 at a clock edge, the bridge SHALL go to IDLE and drive all valids=0, mem_ready=0, mem_rdata=0, bus_error=0, addresses/data=0, bready=1, and counter=0, including when reset arrives mid-transaction.
REQ-022 bus_error SHALL clear only on reset.

Verification
REQ-023 Read: mem_valid with addr 0x0000_0010, wstrb 0; controller stub returns rdata 0x1234_5678 -> arvalid for 1+ cycles, araddr=0x10 stable, rvalid held until rready, mem_ready pulses once with mem_rdata 0x1234_5678.
REQ-024 Write: addr 0x1000_0004, wdata 0xCAFEF00D, wstrb 4'hF -> awvalid then wvalid in sequence, wdata stable, single mem_ready pulse, mem_rdata unchanged.
REQ-025 Timeout: TIMEOUT=8, arready never asserted -> arvalid drops after 8 AR cycles, mem_ready pulses with mem_rdata 0xDEADBEEF, bus_error=1 and stays 1.
REQ-026 Back-to-back: fetch with mem_instr=1 then immediate read -> arprot=3'b100 then 3'b000, at least one idle cycle between rvalid low and the next arvalid.
REQ-027 Reset mid-read: RSTb=0 while in R -> next cycle all valids 0 and mem_ready 0; a fresh read afterwards completes normally.
REQ-028 Race: rready sampled in the same cycle the timeout is reached -> normal completion with the captured rdata and bus_error=0.
